// File: rtl/led_pkg.sv
// Shared types and constants for the APA102-style LED frame sequencer.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE, START_FRAME, FETCH, LED_BYTES, END_FRAME, DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    B_ISSUE, B_WAIT_HI, B_WAIT_LO
  } byte_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam logic [7:0] START_BYTE = 8'h00;
  localparam logic [7:0] END_BYTE   = 8'hFF;
  localparam logic [7:0] LED_HDR    = 8'hE0;

  // End frame needs one clock edge per two LEDs to flush data through the chain.
  function automatic int end_bytes(input int num_leds);
    int n;
    n = (num_leds + 15) / 16;
    return (n > 4) ? n : 4;
  endfunction

endpackage

// File: rtl/led_byte_issue.sv
// One-byte handshake with the SPI byte writer: pulse start, wait busy high, wait busy low.
module led_byte_issue
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] data_byte,
  input  logic       spi_busy,
  output logic       spi_start,
  output logic [7:0] spi_data,
  output logic       byte_done
);

  byte_state_t state, state_nxt;
  logic        issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= B_ISSUE;
      spi_start <= 1'b0;
      spi_data  <= '0;
    end else begin
      state     <= state_nxt;
      spi_start <= issue;
      if (issue) spi_data <= data_byte;
    end
  end

  // spi_data only reloads on issue, so it stays put for the whole transfer.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    byte_done = 1'b0;
    case (state)
      B_ISSUE:   if (go && !spi_busy) begin
                   issue     = 1'b1;
                   state_nxt = B_WAIT_HI;
                 end
      B_WAIT_HI: if (spi_busy) state_nxt = B_WAIT_LO;
      B_WAIT_LO: if (!spi_busy) begin
                   byte_done = 1'b1;
                   state_nxt = B_ISSUE;
                 end
      default:   state_nxt = B_ISSUE;
    endcase
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Streams one LED frame (start zeros, per-LED header/B/G/R, end 0xFF run) to an SPI byte writer.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS   = 60,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  led_clk,
  input  logic                  led_reset_n,
  input  logic                  frame_start,
  input  logic [4:0]            global_brightness,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [23:0]           pix_data,
  output logic                  spi_start,
  output logic [7:0]            spi_data,
  input  logic                  spi_busy
);

  localparam int END_BYTES = end_bytes(NUM_LEDS);
  localparam int CNT_W     = $clog2(END_BYTES + 1);
  localparam int IDX_W     = 8;

  localparam logic [CNT_W-1:0] LAST_QUAD = CNT_W'(3);
  localparam logic [CNT_W-1:0] LAST_END  = CNT_W'(END_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_LED  = IDX_W'(NUM_LEDS - 1);

  seq_state_t            state, state_nxt;
  logic [CNT_W-1:0]      byte_cnt, byte_cnt_nxt;
  logic [IDX_W-1:0]      led_idx, led_idx_nxt;
  logic [4:0]            bright, bright_nxt;
  pixel_t                pixel, pixel_nxt;
  logic                  fetch_ph, fetch_ph_nxt;
  logic [ADDR_WIDTH-1:0] pix_addr_nxt;
  logic                  go, byte_done;
  logic [7:0]            tx_byte;

  always_ff @(posedge led_clk or negedge led_reset_n) begin
    if (!led_reset_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      led_idx  <= '0;
      bright   <= '0;
      pixel    <= '0;
      fetch_ph <= 1'b0;
      pix_addr <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      led_idx  <= led_idx_nxt;
      bright   <= bright_nxt;
      pixel    <= pixel_nxt;
      fetch_ph <= fetch_ph_nxt;
      pix_addr <= pix_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    led_idx_nxt  = led_idx;
    bright_nxt   = bright;
    pixel_nxt    = pixel;
    fetch_ph_nxt = fetch_ph;
    pix_addr_nxt = pix_addr;
    case (state)
      IDLE: begin
        pix_addr_nxt = '0;
        byte_cnt_nxt = '0;
        led_idx_nxt  = '0;
        fetch_ph_nxt = 1'b0;
        if (frame_start) begin
          state_nxt  = START_FRAME;
          bright_nxt = global_brightness;
        end
      end
      START_FRAME: if (byte_done) begin
        if (byte_cnt == LAST_QUAD) begin
          byte_cnt_nxt = '0;
          state_nxt    = FETCH;
        end else byte_cnt_nxt = byte_cnt + 1'b1;
      end
      // Phase 0 lets the RAM see the new address; phase 1 has valid read data.
      FETCH: begin
        if (!fetch_ph) fetch_ph_nxt = 1'b1;
        else begin
          fetch_ph_nxt = 1'b0;
          pixel_nxt    = pixel_t'(pix_data);
          state_nxt    = LED_BYTES;
        end
      end
      LED_BYTES: if (byte_done) begin
        if (byte_cnt == LAST_QUAD) begin
          byte_cnt_nxt = '0;
          if (led_idx < LAST_LED) begin
            led_idx_nxt  = led_idx + 1'b1;
            pix_addr_nxt = ADDR_WIDTH'(led_idx + 1'b1);
            state_nxt    = FETCH;
          end else state_nxt = END_FRAME;
        end else byte_cnt_nxt = byte_cnt + 1'b1;
      end
      END_FRAME: if (byte_done) begin
        if (byte_cnt == LAST_END) begin
          byte_cnt_nxt = '0;
          state_nxt    = DONE;
        end else byte_cnt_nxt = byte_cnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    go      = 1'b0;
    tx_byte = START_BYTE;
    case (state)
      START_FRAME: go = 1'b1;
      LED_BYTES: begin
        go = 1'b1;
        case (byte_cnt[1:0])
          2'd0:    tx_byte = LED_HDR | {3'b000, bright};
          2'd1:    tx_byte = pixel.b;
          2'd2:    tx_byte = pixel.g;
          default: tx_byte = pixel.r;
        endcase
      end
      END_FRAME: begin
        go      = 1'b1;
        tx_byte = END_BYTE;
      end
      default: ;
    endcase
  end

  assign frame_busy = (state == START_FRAME) || (state == FETCH) ||
                      (state == LED_BYTES)   || (state == END_FRAME);
  assign frame_done = (state == DONE);

  led_byte_issue u_issue (
    .clk       (led_clk),
    .rst_n     (led_reset_n),
    .go        (go),
    .data_byte (tx_byte),
    .spi_busy  (spi_busy),
    .spi_start (spi_start),
    .spi_data  (spi_data),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Random-pixel frames against a byte-list model, with a writer model and a scoreboard monitor.
module tb_led_frame_sequencer;

  localparam int NL    = 100;
  localparam int END_B = ((NL + 15) / 16 > 4) ? (NL + 15) / 16 : 4;

  logic        led_clk;
  logic        led_reset_n;
  logic        frame_start;
  logic [4:0]  global_brightness;
  logic        frame_busy;
  logic        frame_done;
  logic [7:0]  pix_addr;
  logic [23:0] pix_data;
  logic        spi_start;
  logic [7:0]  spi_data;
  logic        spi_busy;

  logic [23:0] mem [0:255];
  logic [7:0]  exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          n_starts = 0;
  int          n_done = 0;
  int          peak = 0;
  int          last_peak = 0;
  int          wr_cnt = 0;
  logic [7:0]  wr_byte = 8'h00;
  bit          wr_chk = 1'b0;
  bit          hold_busy = 1'b0;
  bit          done_ok = 1'b0;

  led_frame_sequencer #(.NUM_LEDS(NL), .ADDR_WIDTH(8)) dut (
    .led_clk           (led_clk),
    .led_reset_n       (led_reset_n),
    .frame_start       (frame_start),
    .global_brightness (global_brightness),
    .frame_busy        (frame_busy),
    .frame_done        (frame_done),
    .pix_addr          (pix_addr),
    .pix_data          (pix_data),
    .spi_start         (spi_start),
    .spi_data          (spi_data),
    .spi_busy          (spi_busy)
  );

  initial led_clk = 1'b0;
  always #5 led_clk = ~led_clk;

  always @(posedge led_clk) pix_data <= mem[pix_addr];

  assign spi_busy = (wr_cnt != 0) || hold_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [4:0] br);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < NL; i++) begin
      exp_q.push_back(8'hE0 | {3'b000, br});
      exp_q.push_back(mem[i][7:0]);
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][23:16]);
    end
    for (int i = 0; i < END_B; i++) exp_q.push_back(8'hFF);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 24'($urandom());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  frame_busy, 0);
    chk({tag, "_done"},  frame_done, 0);
    chk({tag, "_start"}, spi_start, 0);
    chk({tag, "_data"},  spi_data, 0);
    chk({tag, "_addr"},  pix_addr, 0);
  endtask

  task automatic run_frame(input logic [4:0] br, input int hold, input int chg_at, input int fs_at);
    int s0, d0, cyc, gaps, early;
    fill_mem();
    push_frame(br);
    s0 = n_starts; d0 = n_done; done_ok = 1'b1; gaps = 0; early = 0;
    global_brightness = br;
    hold_busy = (hold > 0);
    frame_start = 1'b1;
    @(negedge led_clk);
    frame_start = 1'b0;
    chk("busy_after_accept", frame_busy, 1);
    @(negedge led_clk);
    if (hold == 0) chk("first_start_latency", spi_start, 1);
    cyc = 2;
    while (!frame_done && cyc < 20000) begin
      if (cyc < hold && spi_start) early++;
      if (!frame_busy) gaps++;
      @(negedge led_clk);
      cyc++;
      if (cyc == hold) hold_busy = 1'b0;
      if (cyc == chg_at) global_brightness = 5'd31;
      else if (cyc % 97 == 0) global_brightness = 5'($urandom());
      if (cyc == fs_at) frame_start = 1'b1;
      if (cyc == fs_at + 50) frame_start = 1'b0;
    end
    chk("frame_in_time", (cyc < 20000), 1);
    frame_start = 1'b0;
    hold_busy = 1'b0;
    repeat (4) @(negedge led_clk);
    chk("one_done", n_done - d0, 1);
    chk("start_pulses", n_starts - s0, 4 + 4 * NL + END_B);
    chk("peak_addr", last_peak, NL - 1);
    chk("busy_gaps", gaps, 0);
    if (hold > 0) chk("early_start", early, 0);
    chk("idle_after_frame", frame_busy, 0);
    done_ok = 1'b0;
  endtask

  initial begin
    int s0, d0, cyc;
    led_reset_n = 1'b0;
    frame_start = 1'b0;
    global_brightness = 5'd0;
    fill_mem();

    fork
      forever begin
        @(negedge led_clk);
        if (!led_reset_n) wr_chk = 1'b0;
        if (led_reset_n && spi_start) begin
          chk("start_while_busy", spi_busy, 0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start: got byte %0h expected none", spi_data);
          end else chk("byte", spi_data, exp_q.pop_front());
          n_starts++;
          wr_cnt = $urandom_range(1, 8);
          wr_byte = spi_data;
          wr_chk = 1'b1;
        end else if (wr_cnt > 0) begin
          if (wr_chk && led_reset_n) chk("spi_data_stable", spi_data, wr_byte);
          wr_cnt--;
        end
        if (led_reset_n && frame_done) begin
          chk("done_expected", done_ok, 1);
          chk("done_after_all_bytes", exp_q.size(), 0);
          n_done++;
          last_peak = peak;
          peak = 0;
        end
        if (!led_reset_n) peak = 0;
        else if (int'(pix_addr) > peak) peak = int'(pix_addr);
      end
    join_none

    repeat (2) @(negedge led_clk);
    chk_reset_outputs("reset");
    led_reset_n = 1'b1;
    repeat (3) @(negedge led_clk);

    run_frame(5'($urandom()), 0, -1, -1);
    run_frame(5'd3, 0, 100, -1);
    run_frame(5'($urandom()), 0, -1, 300);
    run_frame(5'($urandom()), 20, -1, -1);

    // Abort a frame partway through the first LED's blue byte.
    fill_mem();
    push_frame(5'd9);
    global_brightness = 5'd9;
    done_ok = 1'b0; s0 = n_starts; d0 = n_done;
    frame_start = 1'b1;
    @(negedge led_clk);
    frame_start = 1'b0;
    cyc = 0;
    while (n_starts - s0 < 6 && cyc < 2000) begin
      @(negedge led_clk);
      cyc++;
    end
    chk("reach_led_byte2", n_starts - s0, 6);
    #2 led_reset_n = 1'b0;
    #1 chk_reset_outputs("abort");
    exp_q.delete();
    repeat (3) @(negedge led_clk);
    led_reset_n = 1'b1;
    repeat (20) @(negedge led_clk);
    chk("no_done_on_abort", n_done - d0, 0);
    chk("no_start_after_abort", n_starts - s0, 6);

    run_frame(5'($urandom()), 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
